// File: rtl/line_beat_serializer_pkg.sv
// Local types for the line-to-beat serializer.
package line_beat_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1
  } lbs_state_e;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset (reset wins over enable).
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopr.sv
// Resettable register, synchronous active-high reset.
module flopr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/line_beat_serializer.sv
// Captures a full cache line and streams it out as BEATS beats, lowest beat first,
// over a valid/ready handshake with back-to-back line acceptance on the last beat.
module line_beat_serializer
  import line_beat_serializer_pkg::*;
#(
  parameter int unsigned  LINELEN = 512,
  parameter int unsigned  BEATLEN = 64,
  localparam int unsigned BEATS   = LINELEN / BEATLEN,
  localparam int unsigned CNTW    = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Flush,
  input  logic               LineValid,
  output logic               LineReady,
  input  logic [LINELEN-1:0] Line,
  output logic               BeatValid,
  input  logic               BeatReady,
  output logic [BEATLEN-1:0] Beat,
  output logic [CNTW-1:0]    BeatIdx,
  output logic               BeatLast
);

  localparam int unsigned IW = $clog2(LINELEN);

  lbs_state_e         state, state_next;
  logic [1:0]         state_raw;
  logic [LINELEN-1:0] line_q;
  logic               line_en;
  logic               idx_en;
  logic [CNTW-1:0]    idx_d;
  logic [IW-1:0]      beat_base;

  flopr #(.WIDTH(2)) state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_next),
    .q     (state_raw)
  );

  assign state = lbs_state_e'(state_raw);

  // Line capture register is deliberately not reset; Beat is gated by BeatValid instead.
  flopenr #(.WIDTH(LINELEN)) line_reg (
    .clk   (clk),
    .reset (1'b0),
    .en    (line_en),
    .d     (Line),
    .q     (line_q)
  );

  flopenr #(.WIDTH(CNTW)) idx_reg (
    .clk   (clk),
    .reset (reset),
    .en    (idx_en),
    .d     (idx_d),
    .q     (BeatIdx)
  );

  always_comb begin
    BeatValid = (state == StSend) & ~reset;
    BeatLast  = BeatValid & (BeatIdx == CNTW'(BEATS - 1));
    // Combinational BeatReady -> LineReady path enables bubble-free back-to-back lines.
    LineReady = ~reset & ~Flush & ((state == StIdle) | (BeatLast & BeatReady));
    line_en   = LineValid & LineReady;

    // Increment wraps to 0 after the last beat since BEATS is a power of two.
    idx_en = Flush | line_en | (BeatValid & BeatReady);
    idx_d  = (Flush | (state == StIdle)) ? '0 : BeatIdx + CNTW'(1);

    beat_base = IW'(BeatIdx) * IW'(BEATLEN);
    Beat      = BeatValid ? line_q[beat_base +: BEATLEN] : '0;
  end

  always_comb begin
    state_next = state;
    if (Flush) begin
      state_next = StIdle;
    end else begin
      case (state)
        StIdle:  if (LineValid) state_next = StSend;
        StSend:  if (BeatLast & BeatReady) state_next = LineValid ? StSend : StIdle;
        default: state_next = StIdle;
      endcase
    end
  end

endmodule
